// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a single-port synchronous data RAM (CPU + debug/loader).
// Each access runs IDLE -> ISSUE -> WAIT; the CPU is preferred except when its burst budget is spent.
module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_done,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } acc_t;

    state_t     state, state_nxt;
    acc_t       cpu_acc, dbg_acc, lat;
    logic       gnt;
    logic [3:0] burst_cnt;
    logic       arb, pick_dbg, burst_full;
    logic       unused_addr;

    assign cpu_acc = '{we: cpu_we, addr: cpu_addr[ADDR_W+1:2], wdata: cpu_wdata};
    assign dbg_acc = '{we: dbg_we, addr: dbg_addr[ADDR_W+1:2], wdata: dbg_wdata};

    // Out-of-range and byte-offset address bits are intentionally dropped (wrap).
    assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                           dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    assign burst_full = (burst_cnt == 4'(CPU_BURST));
    assign arb        = (state == S_IDLE) && (cpu_req || dbg_req);
    assign pick_dbg   = dbg_req && (!cpu_req || burst_full);

    // Winner's request is latched so the RAM port is driven from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat       <= '0;
            gnt       <= 1'b0;
            burst_cnt <= 4'd0;
        end else if (arb) begin
            lat <= pick_dbg ? dbg_acc : cpu_acc;
            gnt <= pick_dbg;
            if (pick_dbg || !dbg_req)
                burst_cnt <= 4'd0;
            else if (!burst_full)
                burst_cnt <= burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cpu_req || dbg_req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        cpu_done  = 1'b0;
        dbg_done  = 1'b0;
        cpu_rdata = 32'h0;
        dbg_rdata = 32'h0;
        case (state)
            S_ISSUE: begin
                ram_en = 1'b1;
                ram_we = lat.we ? 4'hF : 4'h0;
            end
            S_WAIT: begin
                cpu_done = !gnt;
                dbg_done = gnt;
                if (!lat.we) begin
                    if (gnt) dbg_rdata = ram_dout;
                    else     cpu_rdata = ram_dout;
                end
            end
            default: ;
        endcase
    end

    assign ram_addr  = lat.addr;
    assign ram_din   = lat.wdata;
    assign busy      = (state != S_IDLE);
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, vector table, scoreboard of expected completions.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0]       cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0]       cpu_rdata, dbg_rdata, ram_din, ram_dout;
    logic              cpu_done, cpu_stall, dbg_done, ram_en, busy;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;

    int chks = 0;
    int errs = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ra;
        logic [31:0] rdata;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];
    logic [31:0] mem[0:(1<<ADDR_W)-1];

    dmem_arbiter #(.ADDR_W(ADDR_W), .CPU_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM with byte enables, read data one cycle after address.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completion pops the oldest expected access.
    always @(negedge clk) begin
        if (!rst && (cpu_done || dbg_done)) begin
            if (q.size() == 0) begin
                chks++;
                errs++;
                $display("FAIL unexpected_done cpu_done=%b dbg_done=%b at %0t", cpu_done, dbg_done, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_port", {31'b0, dbg_done}, {31'b0, e.port});
                chk("both_done", {31'b0, cpu_done & dbg_done}, 32'h0);
                if (!e.we) chk("rdata", e.port ? dbg_rdata : cpu_rdata, e.rdata);
                chk("idle_rdata", e.port ? cpu_rdata : dbg_rdata, 32'h0);
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // Called just after a rising edge with the arbiter idle.
    task automatic run_vec(input vec_t v);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        q.push_back('{port: v.port, we: v.we, rdata: v.rdata});
        @(posedge clk); #1;
        chk("issue_en", {31'b0, ram_en}, 32'h1);
        chk("issue_addr", {22'b0, ram_addr}, v.ra);
        chk("issue_we", {28'b0, ram_we}, v.we ? 32'hF : 32'h0);
        if (v.we) chk("issue_din", ram_din, v.wdata);
        chk("issue_busy", {31'b0, busy}, 32'h1);
        if (!v.port) chk("issue_stall", {31'b0, cpu_stall}, 32'h1);
        @(posedge clk); #1;
        chk("wait_en", {31'b0, ram_en}, 32'h0);
        chk("wait_we", {28'b0, ram_we}, 32'h0);
        chk("wait_done", {31'b0, v.port ? dbg_done : cpu_done}, 32'h1);
        chk("wait_other_done", {31'b0, v.port ? cpu_done : dbg_done}, 32'h0);
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("idle_busy", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h010, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h010, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0FF, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'h0FF, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h001, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         32'h001, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0080, 32'h5555_5555, 32'h020, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h010, 32'hDEAD_BEEF};

        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_ram_en", {31'b0, ram_en}, 32'h0);
        chk("rst_ram_we", {28'b0, ram_we}, 32'h0);
        chk("rst_ram_addr", {22'b0, ram_addr}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_dones", {30'b0, cpu_done, dbg_done}, 32'h0);
        chk("rst_rdata", cpu_rdata | dbg_rdata, 32'h0);
        chk("rst_stall_req", {31'b0, cpu_stall}, 32'h1);
        cpu_req = 1'b0;
        #1 chk("rst_stall_noreq", {31'b0, cpu_stall}, 32'h0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous requests with an empty burst count: CPU first, debug 3 cycles later.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_03FC, 32'h0);
        q.push_back('{port: 1'b0, we: 1'b0, rdata: 32'hDEAD_BEEF});
        q.push_back('{port: 1'b1, we: 1'b0, rdata: 32'h1234_5678});
        #1 chk("sim_stall0", {31'b0, cpu_stall}, 32'h1);
        @(posedge clk); #1;
        chk("sim_stall1", {31'b0, cpu_stall}, 32'h1);
        chk("sim_cpu_addr", {22'b0, ram_addr}, 32'h010);
        @(posedge clk); #1;
        chk("sim_cpu_done", {31'b0, cpu_done}, 32'h1);
        chk("sim_stall_done", {31'b0, cpu_stall}, 32'h0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("sim_gap_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        chk("sim_dbg_addr", {22'b0, ram_addr}, 32'h0FF);
        chk("sim_dbg_done_early", {31'b0, dbg_done}, 32'h0);
        @(posedge clk); #1;
        chk("sim_dbg_done", {31'b0, dbg_done}, 32'h1);
        dbg_req = 1'b0;
        @(posedge clk); #1;

        // Continuous contention: C C C C D C C C C D C C.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_03FC, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (i % 5 == 4) q.push_back('{port: 1'b1, we: 1'b0, rdata: 32'h1234_5678});
            else            q.push_back('{port: 1'b0, we: 1'b0, rdata: 32'hDEAD_BEEF});
        end
        repeat (36) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("cont_drained", q.size(), 32'h0);

        // Reset during ISSUE of a write: no commit, RAM port released at once.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        chk("rst_issue_we", {28'b0, ram_we}, 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_we", {28'b0, ram_we}, 32'h0);
        chk("rst_mid_en", {31'b0, ram_en}, 32'h0);
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        chk("rst_mid_addr", {22'b0, ram_addr}, 32'h0);
        chk("rst_mid_din", ram_din, 32'h0);
        chk("rst_mid_done", {30'b0, cpu_done, dbg_done}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_vec('{1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h020, 32'h5555_5555});

        chk("queue_empty", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data RAM between the pipelined CPU's data port and a secondary debug/loader port. Arbitrates per access, sequences each transaction through a 3-state FSM, drives the RAM port from registered values and returns read data with a one-cycle done pulse. Sits between `mips`/debug loader and the `data_mem` block; the CPU uses `cpu_stall` to freeze its pipeline while its access is outstanding.

## Interface
- `ADDR_W`, 10: RAM word-address width (depth 2^ADDR_W words).
- `CPU_BURST`, 4: max consecutive CPU grants while debug port waits (1..15).
- `clk` in 1: single clock; RAM also clocked on rising `clk`.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_req` in 1: CPU access request, held until `cpu_done`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 32: byte address; word index = `cpu_addr[ADDR_W+1:2]`.
- `cpu_wdata` in 32: write data.
- `cpu_rdata` out 32: read data, valid when `cpu_done`.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_stall` out 1: `cpu_req & ~cpu_done`.
- `dbg_req`, `dbg_we`, `dbg_addr`[32], `dbg_wdata`[32]: debug port, same rules as CPU.
- `dbg_rdata` out 32, `dbg_done` out 1: as CPU.
- `ram_en` out 1, `ram_we` out 4, `ram_addr` out ADDR_W, `ram_din` out 32: RAM port.
- `ram_dout` in 32: RAM read data, one cycle after address.
- `busy` out 1: FSM not in IDLE.

## Operation
- States: IDLE, ISSUE, WAIT. Reset -> IDLE.
- IDLE: if neither req, stay. Otherwise choose winner, latch its we/addr/wdata and `gnt` (0 = CPU, 1 = debug), go ISSUE.
- Winner: only one req -> that port. Both -> CPU, unless `burst_cnt == CPU_BURST`, then debug.
- `burst_cnt` (4 bits): at each arbitration in IDLE:
  - +1 when CPU wins while `dbg_req` is high.
  - Cleared when debug wins, or when CPU wins with `dbg_req` low.
  - Saturates at CPU_BURST.
- ISSUE: `ram_en`=1, `ram_addr`/`ram_din` from latches, `ram_we`=4'hF if write else 4'h0. Always go WAIT.
- WAIT: `ram_en`=0, `ram_we`=0.
  - `done` for `gnt` port = 1; `rdata` for that port = `ram_dout` (reads). Writes also pulse done; rdata don't-care.
  - Always go IDLE.
- Requester drops or changes req only after its done. The req still high in the done cycle is not re-sampled: WAIT never arbitrates.
- Outputs from non-granted port's done are 0. `rdata` of idle port holds 0.
- Address bits above `ADDR_W+1` and [1:0] ignored (wrap modulo 2^ADDR_W words).

## Timing
- Reset values: all outputs 0 (`ram_we`=4'h0, `ram_addr`=0, rdata=0, done=0, busy=0). `cpu_stall` = `cpu_req` during reset. `burst_cnt`=0, `gnt`=0.
- Request sampled at rising edge k in IDLE: ISSUE during cycle k+1, WAIT/done during cycle k+2, IDLE at k+3.
- Fixed latency 2 cycles from grant edge to done. Throughput: one access per 3 cycles.
- Write commits at the rising edge ending ISSUE.
- Simultaneous req both ports in IDLE: resolved the same cycle per burst rule; loser waits ≥3 cycles.
- Reset mid-transaction:
  - Asserted in ISSUE before the edge: write not committed. Async clear forces `ram_we`=0 immediately.
  - Asserted in WAIT: done suppressed.
  - After release: IDLE; pending reqs re-arbitrated.
- `cpu_stall` combinational from `cpu_req` and `cpu_done`. `busy` registered via state.

## Test plan
- Single CPU write then read: write 0x0000_0040 <= 0xDEADBEEF; done at grant+2; read 0x40 -> `cpu_rdata`=0xDEADBEEF with `cpu_done`; `ram_addr`=0x010 both times.
- Debug-only access: dbg write 0x1234_5678 to 0x3FC -> `ram_addr`=0x0FF, `ram_we`=4'hF in ISSUE only; `cpu_done` stays 0.
- Contention: both reqs held continuously, CPU_BURST=4 -> grant order CPU,CPU,CPU,CPU,DBG,CPU,…; `burst_cnt` clears after DBG grant.
- Simultaneous single requests, burst_cnt=0 -> CPU wins. `cpu_stall`=1 for 2 cycles then 0 on `cpu_done`; dbg served next at +3 cycles.
- Reset in ISSUE of a write to 0x80 of 0xAAAA_AAAA -> `ram_we` drops to 0 immediately, memory at 0x80 unchanged on readback, all outputs 0.
- Address wrap: CPU read at 0x0000_1004 with ADDR_W=10 -> `ram_addr`=0x001.
